mem_dp: RTL and testbench
=========================

// Module: mem_dp
// PURPOSE
//  Parametrised simple-dual-port (1 read, 1 write) synchronous RAM that succeeds the single-port mem.
//  Adds independent read/write ports, write byte-enables, and a selectable read latency with a valid strobe.
//  Adds a selectable read-during-write policy and a hardware clear sequencer after reset.
//  Sits between the core datapath and storage; consumers qualify read data with rd_valid.
// PARAMETERS
//  MEM_SIZE       from param.v  address width; depth = 2**MEM_SIZE words
//  DATA_SIZE      from param.v  word width; must be a multiple of 8
//  RD_LAT         1             read latency in cycles, legal values 1 or 2
//  RDW_MODE       0             same-address read+write in one cycle: 0 = return old data, 1 = return new (merged) data
//  CLEAR_ON_RESET 1             1 = zero-fill the whole array after reset; 0 = skip the clear
//  CLR_VAL        0             word value written by the clear sequencer
// PORTS
//  clk        in   1            single clock, all logic on posedge
//  rst_n      in   1            reset, synchronous, active-low
//  rd_en      in   1            read request
//  rd_ad      in   MEM_SIZE     read address
//  rd_data    out  DATA_SIZE    read data, qualified by rd_valid
//  rd_valid   out  1            rd_data carries the result of a request made RD_LAT cycles earlier
//  wr_en      in   1            write request
//  wr_ad      in   MEM_SIZE     write address
//  wr_be      in   DATA_SIZE/8  byte enables; bit i covers wd[8i+7:8i]
//  wd         in   DATA_SIZE    write data
//  init_done  out  1            array is usable; requests are ignored while this is 0
// BEHAVIOUR
//  Reset (rst_n=0 at a posedge):
//   - rd_data=0, rd_valid=0, init_done=0.
//   - Read pipeline flushed.
//   - Clear counter set to 0.
//   - Array contents are not touched by reset itself.
//  FSM states CLEAR and RUN; reset entry is CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
//  CLEAR:
//   - One word per cycle: array[cnt] <= CLR_VAL; cnt increments from 0.
//   - After writing address 2**MEM_SIZE-1, go to RUN. init_done=1 from the next cycle.
//   - Total time from the first non-reset edge to init_done=1 is 2**MEM_SIZE cycles.
//   - rd_en and wr_en are ignored; rd_valid stays 0.
//  RUN: init_done=1.
//   - Write: if wr_en, array[wr_ad] byte i <= wd byte i where wr_be[i]=1; bytes with wr_be[i]=0 are kept.
//   - wr_be=0 with wr_en=1 is a legal no-op.
//  Read latency RD_LAT=1:
//   - rd_en sampled at edge N -> rd_data and rd_valid=1 after edge N.
//   - rd_valid=0 in any cycle that has no read result.
//   - rd_data holds its last value when rd_valid=0. It is not cleared except by reset.
//  Read latency RD_LAT=2:
//   - Stage-1 register plus stage-2 output register; data is valid after edge N+1.
//   - Back-to-back reads give one result per cycle. There is no stall and no backpressure.
//  Collision (rd_en && wr_en && rd_ad==wr_ad in the same cycle):
//   - RDW_MODE=0: returns the pre-write word.
//   - RDW_MODE=1: returns the merged word, i.e. wd where wr_be=1 and the old bytes elsewhere.
//   - The policy is resolved in stage 1 only. Any read issued after the write edge sees the written data.
//  Reset mid-operation:
//   - Reset during CLEAR restarts the clear from address 0.
//   - Reset during RUN drops in-flight reads (no rd_valid for them).
//   - A write sampled on the same edge as reset is not performed.
//  Address wrap: none; the clear counter is MEM_SIZE+1 bits so the terminal check is exact.
//  Out-of-range parameters (RD_LAT not 1 or 2, DATA_SIZE%8!=0): elaboration-time error via a generate-if $error block.
// STRUCTURE
//  param.v, the shared include, owns MEM_SIZE and DATA_SIZE.
//  The same include also gets the new localparams:
//   - BE_W = DATA_SIZE/8.
//   - RDW_OLD=0 and RDW_NEW=1.
//   - ST_CLEAR and ST_RUN encodings.
//  Single flat module: array, write-merge logic, FSM and counter, read pipeline.
//  One natural sub-module: mem_rd_pipe, which takes the stage-1 {valid, data} and adds the optional second register stage.
// TESTING
//  1. Reset release, MEM_SIZE=4, CLEAR_ON_RESET=1 -> init_done rises exactly 16 cycles later; read of every address gives 0; no rd_valid before init_done.
//  2. Write 0xA5 to addr 3 (wr_be all 1s); read addr 3 next cycle -> rd_data=0xA5 with rd_valid 1 cycle (RD_LAT=1) or 2 cycles (RD_LAT=2) after rd_en.
//  3. DATA_SIZE=16: write 0x1234 to addr 5; then write 0xABCD with wr_be=2'b10 -> read returns 0xAB34.
//  4. Addr 7 holds 0x11; same cycle rd_en+wr_en to addr 7 with wd=0x22 -> RDW_MODE=0 returns 0x11 and RDW_MODE=1 returns 0x22; the next read returns 0x22.
//  5. Stream reads on addrs 0..7 on consecutive cycles -> rd_valid high for 8 consecutive cycles and data in order.
//  6. Assert rst_n=0 mid-CLEAR (cnt=9) and mid-stream reads -> rd_valid drops; the clear restarts and init_done rises 16 cycles after reset release.

Source files
------------

// File: rtl/mem_dp_pkg.sv
// Shared definitions for the simple-dual-port RAM: default geometry, read-during-write codes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_dp_pkg;

    // Default geometry used when the instantiating level does not override it.
    localparam int MEM_SIZE_DEF  = 4;
    localparam int DATA_SIZE_DEF = 16;

    // Read-during-write policy codes for RDW_MODE.
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Controller states: zero-fill sweep after reset, then normal operation.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Number of byte lanes in a word of the given width.
    function automatic int be_width(input int data_size);
        return data_size / 8;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read output stage: passes the stage-1 {valid, data} through (RD_LAT=1) or adds one more register (RD_LAT=2).
// Latency: 0 extra cycles for RD_LAT=1, 1 extra cycle for RD_LAT=2.
// Backpressure: none; accepts one result per cycle and never stalls. Data holds while valid is low.
module mem_rd_pipe #(
    parameter int DATA_SIZE = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 s1_vld_i,
    input  logic [DATA_SIZE-1:0] s1_dat_i,
    output logic                 rd_valid_o,
    output logic [DATA_SIZE-1:0] rd_data_o
);

    if (RD_LAT == 2) begin : g_lat2
        logic                 s2_vld_q, s2_vld_d;
        logic [DATA_SIZE-1:0] s2_dat_q, s2_dat_d;

        // Second stage captures each stage-1 result; data is held when no result arrives.
        always_comb begin
            s2_vld_d = s1_vld_i;
            s2_dat_d = s2_dat_q;
            if (s1_vld_i) begin
                s2_dat_d = s1_dat_i;
            end
        end

        // Second-stage register; reset drops any result still in flight.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                s2_vld_q <= 1'b0;
                s2_dat_q <= '0;
            end else begin
                s2_vld_q <= s2_vld_d;
                s2_dat_q <= s2_dat_d;
            end
        end

        assign rd_valid_o = s2_vld_q;
        assign rd_data_o  = s2_dat_q;
    end else begin : g_lat1
        // Single-cycle latency: stage 1 already is the output register.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk_i, rst_n_i};

        assign rd_valid_o = s1_vld_i;
        assign rd_data_o  = s1_dat_i;
    end

endmodule

// File: rtl/mem_dp.sv
// Simple-dual-port synchronous RAM with byte enables, post-reset clear sweep and selectable read latency.
// Latency: read data valid RD_LAT (1 or 2) cycles after rd_en; writes land on the sampling edge.
// Backpressure: none; one read and one write per cycle, requests ignored while init_done_o is low.
module mem_dp
    import mem_dp_pkg::*;
#(
    parameter int                 MEM_SIZE       = MEM_SIZE_DEF,
    parameter int                 DATA_SIZE      = DATA_SIZE_DEF,
    parameter int                 RD_LAT         = 1,
    parameter int                 RDW_MODE       = RDW_OLD,
    parameter int                 CLEAR_ON_RESET = 1,
    parameter logic [DATA_SIZE-1:0] CLR_VAL      = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      rd_en_i,
    input  logic [MEM_SIZE-1:0]       rd_ad_i,
    output logic [DATA_SIZE-1:0]      rd_data_o,
    output logic                      rd_valid_o,
    input  logic                      wr_en_i,
    input  logic [MEM_SIZE-1:0]       wr_ad_i,
    input  logic [DATA_SIZE/8-1:0]    wr_be_i,
    input  logic [DATA_SIZE-1:0]      wd_i,
    output logic                      init_done_o
);

    localparam int                DEPTH    = 1 << MEM_SIZE;
    localparam int                BE_W     = be_width(DATA_SIZE);
    // Counter is one bit wider than the address so the last-address test is exact.
    localparam logic [MEM_SIZE:0] CNT_LAST = (MEM_SIZE + 1)'(DEPTH - 1);
    localparam state_e            ST_RST   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    // Reject geometries and latencies the datapath cannot build.
    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_lat
        $error("mem_dp: RD_LAT must be 1 or 2");
    end
    if ((DATA_SIZE % 8) != 0) begin : g_bad_width
        $error("mem_dp: DATA_SIZE must be a multiple of 8");
    end

    // Storage array; deliberately not reset, the clear sweep initialises it.
    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    // Controller state.
    state_e            state_q, state_d;
    logic [MEM_SIZE:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic              clr_go;

    // Request qualification and write merge.
    logic                 wr_go;
    logic                 rd_go;
    logic                 rd_hit_wr;
    logic [DATA_SIZE-1:0] wr_old;
    logic [DATA_SIZE-1:0] wr_merged;

    // Stage-1 read register.
    logic                 s1_vld_q, s1_vld_d;
    logic [DATA_SIZE-1:0] s1_dat_q, s1_dat_d;
    logic [DATA_SIZE-1:0] rd_word;

    // Requests only count once the array is usable; init_done is the gate.
    assign wr_go     = wr_en_i && init_done_q;
    assign rd_go     = rd_en_i && init_done_q;
    assign rd_hit_wr = wr_go && (rd_ad_i == wr_ad_i);

    // Next state: sweep one word per cycle in CLEAR, leave after the last address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_go  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_go = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
        init_done_d = (state_d == ST_RUN);
    end

    // Controller registers; reset restarts the sweep from address 0.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_RST;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Byte-lane merge: enabled lanes take the new data, others keep the stored bytes.
    always_comb begin
        wr_old    = mem_q[wr_ad_i];
        wr_merged = wr_old;
        for (int b = 0; b < BE_W; b++) begin
            if (wr_be_i[b]) begin
                wr_merged[8*b +: 8] = wd_i[8*b +: 8];
            end
        end
    end

    // Array update: clear sweep or user write; nothing is written on a reset edge.
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            if (clr_go) begin
                mem_q[cnt_q[MEM_SIZE-1:0]] <= CLR_VAL;
            end else if (wr_go) begin
                mem_q[wr_ad_i] <= wr_merged;
            end
        end
    end

    // Stage-1 read mux: same-address collisions resolved here according to RDW_MODE.
    always_comb begin
        rd_word = mem_q[rd_ad_i];
        if ((RDW_MODE == RDW_NEW) && rd_hit_wr) begin
            rd_word = wr_merged;
        end
        s1_vld_d = rd_go;
        s1_dat_d = s1_dat_q;
        if (rd_go) begin
            s1_dat_d = rd_word;
        end
    end

    // Stage-1 register; reset flushes in-flight reads and zeroes the data.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_vld_q <= 1'b0;
            s1_dat_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_dat_q <= s1_dat_d;
        end
    end

    mem_rd_pipe #(
        .DATA_SIZE (DATA_SIZE),
        .RD_LAT    (RD_LAT)
    ) u_rd_pipe (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .s1_vld_i   (s1_vld_q),
        .s1_dat_i   (s1_dat_q),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o)
    );

    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_mem_dp.sv
// Directed bench for mem_dp: two instances share stimulus (d0: RD_LAT=1/old-data, d1: RD_LAT=2/new-data).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none in the DUT; stimulus issues back-to-back requests freely.
module tb_mem_dp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic [3:0]  rd_ad;
    logic        wr_en;
    logic [3:0]  wr_ad;
    logic [1:0]  be;
    logic [15:0] wd;

    logic [15:0] d0_dat, d1_dat;
    logic        d0_vld, d1_vld;
    logic        d0_done, d1_done;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Table for the back-to-back phase, hand-chosen values.
    logic [15:0] tbl [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                             16'h5555, 16'h6666, 16'h7777, 16'h8888};

    always #5 clk = ~clk;

    mem_dp #(.MEM_SIZE(4), .DATA_SIZE(16), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1), .CLR_VAL(16'h0000)) d0 (
        .clk_i(clk), .rst_n_i(rst_n), .rd_en_i(rd_en), .rd_ad_i(rd_ad), .rd_data_o(d0_dat), .rd_valid_o(d0_vld),
        .wr_en_i(wr_en), .wr_ad_i(wr_ad), .wr_be_i(be), .wd_i(wd), .init_done_o(d0_done));

    mem_dp #(.MEM_SIZE(4), .DATA_SIZE(16), .RD_LAT(2), .RDW_MODE(1), .CLEAR_ON_RESET(1), .CLR_VAL(16'h0000)) d1 (
        .clk_i(clk), .rst_n_i(rst_n), .rd_en_i(rd_en), .rd_ad_i(rd_ad), .rd_data_o(d1_dat), .rd_valid_o(d1_vld),
        .wr_en_i(wr_en), .wr_ad_i(wr_ad), .wr_be_i(be), .wd_i(wd), .init_done_o(d1_done));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        wr_en = 1'b1; wr_ad = a; wd = d; be = b;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; rd_ad = '0; wr_ad = '0; wd = '0; be = '0;
        cyc(); cyc();
        tot_cnt++;
        if ({d0_vld, d0_dat, d0_done} !== 18'h0) $display("FAIL reset_d0 got vld=%b dat=%h done=%b want 0/0000/0", d0_vld, d0_dat, d0_done);
        else pass_cnt++;
        tot_cnt++;
        if ({d1_vld, d1_dat, d1_done} !== 18'h0) $display("FAIL reset_d1 got vld=%b dat=%h done=%b want 0/0000/0", d1_vld, d1_dat, d1_done);
        else pass_cnt++;
        // Requests during the sweep must be ignored.
        rst_n = 1'b1; rd_en = 1'b1; rd_ad = 4'd3; wr_en = 1'b1; wr_ad = 4'd3; wd = 16'hFFFF; be = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k == 16) begin rd_en = 1'b0; wr_en = 1'b0; end
            tot_cnt++;
            if (d0_done !== (k == 16) || d1_done !== (k == 16) || d0_vld !== 1'b0 || d1_vld !== 1'b0)
                $display("FAIL clear_timing k=%0d got done=%b/%b vld=%b/%b want done=%b vld=0", k, d0_done, d1_done, d0_vld, d1_vld, (k == 16));
            else pass_cnt++;
        end
        // Every word reads back as the clear value.
        for (int c = 0; c <= 16; c++) begin
            rd_en = (c < 16); rd_ad = 4'(c);
            cyc();
            tot_cnt++;
            if (c < 16 ? (d0_vld !== 1'b1 || d0_dat !== 16'h0) : (d0_vld !== 1'b0))
                $display("FAIL clear_read_d0 c=%0d got vld=%b dat=%h want vld=%b dat=0000", c, d0_vld, d0_dat, (c < 16));
            else pass_cnt++;
            tot_cnt++;
            if (c >= 1 ? (d1_vld !== 1'b1 || d1_dat !== 16'h0) : (d1_vld !== 1'b0))
                $display("FAIL clear_read_d1 c=%0d got vld=%b dat=%h want vld=%b dat=0000", c, d1_vld, d1_dat, (c >= 1));
            else pass_cnt++;
        end
        rd_en = 1'b0;
    endtask

    task automatic test_write_read();
        write_word(4'd3, 16'h00A5, 2'b11);
        rd_en = 1'b1; rd_ad = 4'd3;
        cyc();
        rd_en = 1'b0;
        tot_cnt++;
        if (d0_vld !== 1'b1 || d0_dat !== 16'h00A5 || d1_vld !== 1'b0)
            $display("FAIL wr_rd_c1 got d0=%b/%h d1_vld=%b want 1/00a5 d1_vld=0", d0_vld, d0_dat, d1_vld);
        else pass_cnt++;
        cyc();
        tot_cnt++;
        if (d0_vld !== 1'b0 || d0_dat !== 16'h00A5 || d1_vld !== 1'b1 || d1_dat !== 16'h00A5)
            $display("FAIL wr_rd_c2 got d0=%b/%h d1=%b/%h want 0/00a5 1/00a5", d0_vld, d0_dat, d1_vld, d1_dat);
        else pass_cnt++;
    endtask

    task automatic test_byte_enable();
        write_word(4'd5, 16'h1234, 2'b11);
        write_word(4'd5, 16'hABCD, 2'b10);
        write_word(4'd5, 16'hFFFF, 2'b00);
        rd_en = 1'b1; rd_ad = 4'd5;
        cyc();
        rd_en = 1'b0;
        tot_cnt++;
        if (d0_vld !== 1'b1 || d0_dat !== 16'hAB34)
            $display("FAIL byte_en_d0 got %b/%h want 1/ab34", d0_vld, d0_dat);
        else pass_cnt++;
        cyc();
        tot_cnt++;
        if (d1_vld !== 1'b1 || d1_dat !== 16'hAB34)
            $display("FAIL byte_en_d1 got %b/%h want 1/ab34", d1_vld, d1_dat);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        write_word(4'd7, 16'h0011, 2'b11);
        // Full-word collision.
        rd_en = 1'b1; rd_ad = 4'd7; wr_en = 1'b1; wr_ad = 4'd7; wd = 16'h0022; be = 2'b11;
        cyc();
        rd_en = 1'b0; wr_en = 1'b0;
        tot_cnt++;
        if (d0_vld !== 1'b1 || d0_dat !== 16'h0011 || d1_vld !== 1'b0)
            $display("FAIL rdw_old got d0=%b/%h d1_vld=%b want 1/0011 d1_vld=0", d0_vld, d0_dat, d1_vld);
        else pass_cnt++;
        cyc();
        tot_cnt++;
        if (d1_vld !== 1'b1 || d1_dat !== 16'h0022)
            $display("FAIL rdw_new got %b/%h want 1/0022", d1_vld, d1_dat);
        else pass_cnt++;
        rd_en = 1'b1; rd_ad = 4'd7;
        cyc();
        rd_en = 1'b0;
        tot_cnt++;
        if (d0_vld !== 1'b1 || d0_dat !== 16'h0022)
            $display("FAIL rdw_after_d0 got %b/%h want 1/0022", d0_vld, d0_dat);
        else pass_cnt++;
        cyc();
        tot_cnt++;
        if (d1_vld !== 1'b1 || d1_dat !== 16'h0022)
            $display("FAIL rdw_after_d1 got %b/%h want 1/0022", d1_vld, d1_dat);
        else pass_cnt++;
        // Partial-lane collision: new policy returns the merged word.
        rd_en = 1'b1; rd_ad = 4'd7; wr_en = 1'b1; wr_ad = 4'd7; wd = 16'h5566; be = 2'b10;
        cyc();
        rd_en = 1'b0; wr_en = 1'b0;
        tot_cnt++;
        if (d0_vld !== 1'b1 || d0_dat !== 16'h0022)
            $display("FAIL rdw_part_old got %b/%h want 1/0022", d0_vld, d0_dat);
        else pass_cnt++;
        cyc();
        tot_cnt++;
        if (d1_vld !== 1'b1 || d1_dat !== 16'h5522)
            $display("FAIL rdw_part_new got %b/%h want 1/5522", d1_vld, d1_dat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 8; a++) begin
            wr_en = 1'b1; wr_ad = 4'(a); wd = tbl[a]; be = 2'b11;
            cyc();
        end
        wr_en = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            rd_en = (c < 8); rd_ad = 4'(c);
            cyc();
            tot_cnt++;
            if (c < 8 ? (d0_vld !== 1'b1 || d0_dat !== tbl[c]) : (d0_vld !== 1'b0))
                $display("FAIL b2b_d0 c=%0d got vld=%b dat=%h want vld=%b dat=%h", c, d0_vld, d0_dat, (c < 8), tbl[c % 8]);
            else pass_cnt++;
            tot_cnt++;
            if (c >= 1 ? (d1_vld !== 1'b1 || d1_dat !== tbl[(c + 7) % 8]) : (d1_vld !== 1'b0))
                $display("FAIL b2b_d1 c=%0d got vld=%b dat=%h want vld=%b dat=%h", c, d1_vld, d1_dat, (c >= 1), tbl[(c + 7) % 8]);
            else pass_cnt++;
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        // Address 12 is beyond the point where the first sweep is interrupted.
        write_word(4'd12, 16'h0C0C, 2'b11);
        rd_en = 1'b1; rd_ad = 4'd0;
        cyc();
        rst_n = 1'b0; rd_ad = 4'd1;
        cyc();
        rd_en = 1'b0;
        tot_cnt++;
        if (d0_vld !== 1'b0 || d1_vld !== 1'b0 || d0_dat !== 16'h0 || d1_dat !== 16'h0 || d0_done !== 1'b0 || d1_done !== 1'b0)
            $display("FAIL mid_reset got vld=%b/%b dat=%h/%h done=%b/%b want all 0", d0_vld, d1_vld, d0_dat, d1_dat, d0_done, d1_done);
        else pass_cnt++;
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            tot_cnt++;
            if (d0_vld !== 1'b0 || d1_vld !== 1'b0 || d0_done !== 1'b0 || d1_done !== 1'b0)
                $display("FAIL mid_clear k=%0d got vld=%b/%b done=%b/%b want 0", k, d0_vld, d1_vld, d0_done, d1_done);
            else pass_cnt++;
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            tot_cnt++;
            if (d0_done !== (k == 16) || d1_done !== (k == 16))
                $display("FAIL restart_timing k=%0d got done=%b/%b want %b", k, d0_done, d1_done, (k == 16));
            else pass_cnt++;
        end
        rd_en = 1'b1; rd_ad = 4'd12;
        cyc();
        rd_en = 1'b0;
        tot_cnt++;
        if (d0_vld !== 1'b1 || d0_dat !== 16'h0)
            $display("FAIL restart_clear_d0 got %b/%h want 1/0000", d0_vld, d0_dat);
        else pass_cnt++;
        cyc();
        tot_cnt++;
        if (d1_vld !== 1'b1 || d1_dat !== 16'h0)
            $display("FAIL restart_clear_d1 got %b/%h want 1/0000", d1_vld, d1_dat);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
